// File: rtl/s2p_converter_if.sv
// Serial-in / parallel-out handshake bundle for s2p_converter.
// The master modport is the side that drives serial bits and consumes words.
interface s2p_converter_if #(
    parameter int N = 4
);
    logic         ser_valid;
    logic         ser_data;
    logic         ser_ready;
    logic         par_valid;
    logic [N-1:0] par_data;
    logic         par_ready;

    modport master (
        output ser_valid, ser_data, par_ready,
        input  ser_ready, par_valid, par_data
    );

    modport slave (
        input  ser_valid, ser_data, par_ready,
        output ser_ready, par_valid, par_data
    );
endinterface

// File: rtl/s2p_converter.sv
// Serial-to-parallel converter: assembles N serial bits into a word and holds
// it in a one-word output register behind a valid/ready handshake.
module s2p_converter #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    s2p_converter_if.slave  bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e    out_state_q, out_state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;

    logic          ser_ready;
    logic          accept;
    logic          take;
    logic [N-1:0]  sh_next;

    // Only the last bit of a word needs room in the output register.
    always_comb begin
        ser_ready = !clr && ((cnt_q != LAST) || (out_state_q == OUT_EMPTY) || bus.par_ready);
        accept    = bus.ser_valid && ser_ready;
        take      = (out_state_q == OUT_FULL) && bus.par_ready;
        if (MSB_FIRST) begin
            sh_next = {sh_q[N-2:0], bus.ser_data};
        end else begin
            sh_next = {bus.ser_data, sh_q[N-1:1]};
        end
    end

    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        out_state_d = out_state_q;

        if (take) begin
            out_state_d = OUT_EMPTY;
        end

        if (clr) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (accept) begin
            sh_d = sh_next;
            if (cnt_q == LAST) begin
                cnt_d       = '0;
                data_d      = sh_next;
                out_state_d = OUT_FULL;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q        <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            out_state_q <= OUT_EMPTY;
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            out_state_q <= out_state_d;
        end
    end

    assign bus.ser_ready = ser_ready;
    assign bus.par_valid = (out_state_q == OUT_FULL);
    assign bus.par_data  = data_q;
endmodule
